// File: rtl/fpcvt_pkg.sv
// Shared types and widths for the fp converter arbiter slice.
// 12-bit two's-complement samples become packed {S,E,F} 1/3/4 minifloats.
package fpcvt_pkg;

   localparam int DATA_W = 12;
   localparam int E_W    = 3;
   localparam int F_W    = 4;

   typedef enum logic [1:0] {IDLE, CONV, DONE} fpcvt_state_t;

   typedef struct packed {
      logic           s;
      logic [E_W-1:0] e;
      logic [F_W-1:0] f;
   } fp8_t;

endpackage

// File: rtl/fp_convert.sv
// Purely combinational 12-bit two's-complement to {S,E,F} minifloat converter
// with round-half-up on the bit below the significand and saturation at E=7,F=15.
module fp_convert
   import fpcvt_pkg::*;
(
   input  logic [DATA_W-1:0]      i_d,
   output logic [1+E_W+F_W-1:0]   o_fp
);

   logic [DATA_W-1:0] w_mag;
   logic [E_W-1:0]    w_e;
   logic [F_W-1:0]    w_f;
   logic              w_r;
   fp8_t              w_res;

   always_comb begin
      w_mag = i_d[DATA_W-1] ? (~i_d + 12'd1) : i_d;

      // Exponent tracks the highest set bit in 4..10; below that E stays 0.
      w_e = '0;
      for (int unsigned k = 1; k < 8; k++) begin
         if (w_mag[k+3]) w_e = E_W'(k);
      end

      w_f = w_mag[F_W-1:0];
      w_r = 1'b0;
      if (w_e != '0) begin
         w_f = F_W'(w_mag >> w_e);
         w_r = w_mag[w_e - 3'd1];
      end

      w_res.s = i_d[DATA_W-1];
      w_res.e = w_e;
      w_res.f = w_f;
      if (w_mag == 12'h800) begin
         w_res.e = '1;
         w_res.f = '1;
      end else if (w_r) begin
         if (w_f != '1) begin
            w_res.f = w_f + 4'd1;
         end else if (w_e != '1) begin
            w_res.f = 4'd8;
            w_res.e = w_e + 3'd1;
         end
      end
   end

   assign o_fp = w_res;

endmodule

// File: rtl/fpcvt_arbiter.sv
// Round-robin arbiter sharing one fp_convert between N_REQ valid/ready sources;
// each accepted sample is converted and presented with its requester ID.
module fpcvt_arbiter
   import fpcvt_pkg::*;
#(
   parameter int N_REQ = 4,
   parameter int ID_W  = $clog2(N_REQ)
) (
   input  logic                    i_clk,
   input  logic                    i_rst,
   input  logic [N_REQ-1:0]        i_req_valid,
   input  logic [N_REQ*DATA_W-1:0] i_req_data,
   output logic [N_REQ-1:0]        o_req_ready,
   output logic                    o_out_valid,
   input  logic                    i_out_ready,
   output logic [ID_W-1:0]         o_out_id,
   output logic                    o_out_s,
   output logic [E_W-1:0]          o_out_e,
   output logic [F_W-1:0]          o_out_f
);

   fpcvt_state_t      r_state;
   fpcvt_state_t      w_next;
   logic [ID_W-1:0]   r_rr_ptr;
   logic [DATA_W-1:0] r_op;
   logic [ID_W-1:0]   r_id;
   logic [ID_W-1:0]   r_out_id;
   fp8_t              r_out;
   fp8_t              w_fp;
   logic [ID_W-1:0]   w_grant;
   logic              w_any;
   logic              w_hs;
   logic [ID_W:0]     w_idx;

   fp_convert u_conv (
      .i_d  (r_op),
      .o_fp (w_fp)
   );

   // Search starts at r_rr_ptr; the ID_W+1 bit sum never overflows before wrap.
   always_comb begin
      w_grant = '0;
      w_any   = 1'b0;
      w_idx   = '0;
      for (int unsigned k = 0; k < N_REQ; k++) begin
         w_idx = (ID_W+1)'(r_rr_ptr) + (ID_W+1)'(k);
         if (w_idx >= (ID_W+1)'(N_REQ)) w_idx = w_idx - (ID_W+1)'(N_REQ);
         if (!w_any && i_req_valid[w_idx[ID_W-1:0]]) begin
            w_any   = 1'b1;
            w_grant = w_idx[ID_W-1:0];
         end
      end
   end

   assign w_hs = (r_state == IDLE) && w_any;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) r_state <= IDLE;
      else       r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      unique case (r_state)
         IDLE:    if (w_any) w_next = CONV;
         CONV:    w_next = DONE;
         DONE:    if (i_out_ready) w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   always_comb begin
      o_req_ready = '0;
      if (w_hs) o_req_ready[w_grant] = 1'b1;
      o_out_valid = (r_state == DONE);
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_rr_ptr <= '0;
         r_op     <= '0;
         r_id     <= '0;
         r_out_id <= '0;
         r_out    <= '0;
      end else begin
         if (w_hs) begin
            r_op     <= i_req_data[w_grant*DATA_W +: DATA_W];
            r_id     <= w_grant;
            r_rr_ptr <= (w_grant == ID_W'(N_REQ-1)) ? '0 : w_grant + 1'b1;
         end
         if (r_state == CONV) begin
            r_out    <= w_fp;
            r_out_id <= r_id;
         end
      end
   end

   assign o_out_id = r_out_id;
   assign o_out_s  = r_out.s;
   assign o_out_e  = r_out.e;
   assign o_out_f  = r_out.f;

endmodule
